// File: rtl/tz_normalize.sv
// Trailing-zero normaliser: shifts a word right until bit 0 is set, at most 2**P_STEP_LOG2 bits per cycle.
// Optional macro TZN_ZERO_DETECT_EN short-circuits all-zero words straight to DONE.
module tz_normalize #(
   parameter int P_WIDTH     = 256,
   parameter int P_STEP_LOG2 = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [P_WIDTH-1:0]         in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [P_WIDTH-1:0]         out_data,
   output logic [$clog2(P_WIDTH):0]   out_count,
   output logic                       out_zero
);

   localparam int CW   = $clog2(P_WIDTH) + 1;
   localparam int STEP = 2 ** P_STEP_LOG2;
   localparam int ZW   = P_STEP_LOG2 + 1;
   localparam logic [ZW-1:0] STEP_Z = ZW'(STEP);
   localparam logic [CW-1:0] FULL   = CW'(P_WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state, state_next;
   logic [P_WIDTH-1:0]   work, work_next;
   logic [CW-1:0]        count, count_next;
   logic                 zero, zero_next;
   logic [ZW-1:0]        z;
   logic [CW-1:0]        sum;

   // Lowest set bit within the bottom STEP bits; STEP when that window is empty.
   always_comb begin
      z = STEP_Z;
      for (int i = STEP - 1; i >= 0; i--) begin
         if (work[i]) z = ZW'(i);
      end
   end

   assign sum = count + CW'(z);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      work_next  = work;
      count_next = count;
      zero_next  = zero;
      case (state)
         IDLE: begin
            if (in_valid) begin
               work_next  = in_data;
               count_next = '0;
               zero_next  = 1'b0;
               state_next = SHIFT;
`ifdef TZN_ZERO_DETECT_EN
               if (in_data == '0) begin
                  count_next = FULL;
                  zero_next  = 1'b1;
                  state_next = DONE;
               end
`endif
            end
         end
         SHIFT: begin
            work_next = work >> z;
            if (sum >= FULL) begin
               count_next = FULL;
               zero_next  = 1'b1;
               state_next = DONE;
            end else begin
               count_next = sum;
               if (z < STEP_Z) state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         work  <= '0;
         count <= '0;
         zero  <= 1'b0;
      end else begin
         state <= state_next;
         work  <= work_next;
         count <= count_next;
         zero  <= zero_next;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = work;
   assign out_count = count;
   assign out_zero  = zero;

endmodule

// File: doc/tz_normalize.md
TZ_NORMALIZE -- requirements
Module: tz_normalize

Interface
REQ-001 SHALL have parameter P_WIDTH, default 256: data width; power of two, >= 2**P_STEP_LOG2.
REQ-002 SHALL have parameter P_STEP_LOG2, default 4: log2 of the maximum right shift per cycle; range 1 to $clog2(P_WIDTH).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active low.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a word.
REQ-007 SHALL have port in_data, input, P_WIDTH bits: word to normalise.
REQ-008 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port out_data, output, P_WIDTH bits: in_data logically right-shifted by out_count.
REQ-011 SHALL have port out_count, output, $clog2(P_WIDTH)+1 bits: trailing-zero count of in_data, 0..P_WIDTH.
REQ-012 SHALL have port out_zero, output, 1 bit: in_data was all zeros.

Function
REQ-013 SHALL implement three states, IDLE, SHIFT and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL treat a transfer on in_valid&in_ready as accepting the word: load the work register with in_data, clear the count and enter SHIFT; in_data is ignored in any other state.
REQ-015 SHALL, in each SHIFT cycle, compute z = trailing zeros in the low 2**P_STEP_LOG2 bits of the work register (z = 2**P_STEP_LOG2 if all are zero), shift the work register right by z with zero fill, and add z to the count.
REQ-016 SHALL move from SHIFT to DONE when z < 2**P_STEP_LOG2, or when the updated count >= P_WIDTH; otherwise it SHALL stay in SHIFT.
REQ-017 SHALL saturate the count at P_WIDTH and set out_zero when the count reaches P_WIDTH.
REQ-018 SHALL, for nonzero input with trailing-zero count tz, spend floor(tz/2**P_STEP_LOG2)+1 cycles in SHIFT; out_valid SHALL rise that many edges plus one after the accept edge.
REQ-019 SHALL hold out_data, out_count and out_zero stable in DONE while out_ready=0.
REQ-020 SHALL return from DONE to IDLE on out_valid&out_ready; in_ready SHALL rise the following cycle, with no same-cycle accept from DONE.
REQ-021 SHALL keep out_data, out_count and out_zero equal to the work register, count and zero flag in every state; they are meaningful only while out_valid=1.

Reset
REQ-022 SHALL, while rst_n=0, force state IDLE, the work register to 0, the count to 0 and out_zero to 0, asynchronously; in_ready=1 and out_valid=0.
REQ-023 SHALL abandon any operation in progress when reset is asserted in SHIFT or DONE, produce no out_valid for the abandoned word, and accept a new word on the first edge after rst_n deasserts.

Configuration
REQ-024 SHALL honour macro TZN_ZERO_DETECT_EN.
- When defined: an accepted all-zero in_data goes IDLE->DONE directly, with count=P_WIDTH, out_zero=1, out_data=0; out_valid is high one edge after accept.
- When undefined: an all-zero word follows REQ-015/016 and spends P_WIDTH/2**P_STEP_LOG2 cycles in SHIFT, with the same final outputs.

Verification
REQ-025 SHALL cover, at P_WIDTH=256, P_STEP_LOG2=4: in_data=1 -> out_valid 2 edges after accept; count=0; data=1; zero=0.
REQ-026 SHALL cover in_data=1<<40 -> 3 SHIFT cycles (z=16,16,8); out_valid 4 edges after accept; count=40; data=1.
REQ-027 SHALL cover in_data=1<<255 -> 16 SHIFT cycles; count=255; data=1; zero=0.
REQ-028 SHALL cover in_data=0 -> count=256, data=0, zero=1, with out_valid 1 edge after accept when TZN_ZERO_DETECT_EN is defined and 17 edges after accept when it is not.
REQ-029 SHALL cover in_data=0xA0 with out_ready=0 for 5 cycles -> count=5 and data=0x5 held stable; in_ready=0 throughout; in_ready=1 one cycle after out_ready rises.
REQ-030 SHALL cover rst_n pulsed low mid-SHIFT on in_data=1<<200 -> out_valid never asserts for that word; next word 0x8 -> count=3.
